// File: rtl/flag_scheduler_pkg.sv
// Shared definitions for the flag scheduler: ARM condition codes, status bit
// positions and the scheduler state encoding.
package flag_scheduler_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NK = 4'hF
    } cond_e;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_STALLED  = 2'd2
    } state_e;

    // AL and NK resolve without looking at the flags, so they never wait on writers.
    function automatic logic cond_uses_flags(cond_e c);
        return !((c == COND_AL) || (c == COND_NK));
    endfunction

endpackage

// File: rtl/flag_scheduler_cond.sv
// Condition_Check: evaluates an ARM condition field against a {Z,C,N,V} flag set.
module Condition_Check
    import flag_scheduler_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic z, c, n, v;

    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign n = flags_i[FLAG_N];
    assign v = flags_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_scheduler.sv
// Flag scheduler: tracks in-flight flag writers, stalls dependent conditional
// issues and forwards retiring flags to the condition check in the same cycle.
module flag_scheduler
    import flag_scheduler_pkg::*;
#(
    parameter int MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [3:0] issue_cond,
    input  logic       issue_s,
    output logic       issue_ready,
    output logic       issue_exec,
    input  logic       wb_flag_valid,
    input  logic [3:0] wb_status,
    input  logic       flush,
    output logic [3:0] status_q,
    output logic [1:0] pend_cnt,
    output logic [7:0] stall_cnt,
    output logic       err
);

    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

    state_e     state_q, state_d;
    logic [3:0] status_r_q, status_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] stall_q, stall_d;
    logic       err_q, err_d;

    logic [3:0] eval_flags;
    logic       cond_pass, none_pending, eff_pending;
    logic       flag_stall, full_stall, blocked;
    logic       accept_inc, wb_take, wb_err;

    // IDLE is held exactly when nothing is in flight, so the state doubles as the zero test.
    assign none_pending = (state_q == ST_IDLE);
    assign eff_pending  = (pend_q > {1'b0, wb_flag_valid});

    assign eval_flags = (wb_flag_valid && (pend_q == 2'd1)) ? wb_status : status_r_q;

    Condition_Check u_cond (
        .cond_i  (issue_cond),
        .flags_i (eval_flags),
        .pass_o  (cond_pass)
    );

    assign flag_stall  = cond_uses_flags(cond_e'(issue_cond)) && eff_pending;
    assign full_stall  = issue_s && (pend_q == PEND_MAX) && !wb_flag_valid;
    assign issue_ready = !rst && !flush && !flag_stall && !full_stall;
    assign issue_exec  = issue_ready && cond_pass;

    assign blocked    = issue_valid && !issue_ready && !flush;
    assign accept_inc = issue_valid && issue_exec && issue_s;
    assign wb_take    = wb_flag_valid && !flush && !none_pending;
    assign wb_err     = wb_flag_valid && !flush && none_pending;

    always_comb begin
        pend_d   = pend_q;
        status_d = status_r_q;
        stall_d  = stall_q;
        err_d    = err_q | wb_err;
        state_d  = ST_IDLE;

        if (flush) begin
            pend_d = 2'd0;
        end else begin
            case ({accept_inc, wb_take})
                2'b10:   pend_d = pend_q + 2'd1;
                2'b01:   pend_d = pend_q - 2'd1;
                default: pend_d = pend_q;
            endcase
        end

        if (wb_take) begin
            status_d = wb_status;
        end

        if (blocked && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end

        if (blocked) begin
            state_d = ST_STALLED;
        end else if (pend_d != 2'd0) begin
            state_d = ST_INFLIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            status_r_q <= 4'b0000;
            pend_q     <= 2'd0;
            stall_q    <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_r_q <= status_d;
            pend_q     <= pend_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign status_q  = status_r_q;
    assign pend_cnt  = pend_q;
    assign stall_cnt = stall_q;
    assign err       = err_q;

endmodule

// File: tb/tb_flag_scheduler.sv
// Bench for flag_scheduler: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_flag_scheduler;
    import flag_scheduler_pkg::*;

    localparam int MAXP = 3;

    logic       clk = 1'b0;
    logic       rst, issue_valid, issue_s, wb_flag_valid, flush;
    logic [3:0] issue_cond, wb_status;
    logic       issue_ready, issue_exec, err;
    logic [3:0] status_q;
    logic [1:0] pend_cnt;
    logic [7:0] stall_cnt;

    int n_pass = 0;
    int n_tot  = 0;
    bit checking = 1'b0;

    typedef struct {
        int status;
        int pend;
        int stall;
        int err;
        int st;
    } mstate_t;

    mstate_t m = '{0, 0, 0, 0, 0};

    flag_scheduler #(.MAX_PEND(MAXP)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_cond(issue_cond), .issue_s(issue_s),
        .issue_ready(issue_ready), .issue_exec(issue_exec),
        .wb_flag_valid(wb_flag_valid), .wb_status(wb_status), .flush(flush),
        .status_q(status_q), .pend_cnt(pend_cnt), .stall_cnt(stall_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ARM condition table applied to a flag nibble {Z,C,N,V}.
    function automatic bit holds(int cond, int f);
        bit z = f[3], c = f[2], n = f[1], v = f[0];
        case (cond)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_ready(mstate_t s);
        int eff;
        if (rst || flush) return 1'b0;
        eff = s.pend - int'(wb_flag_valid);
        if (int'(issue_cond) < 14 && eff > 0) return 1'b0;
        if (issue_s && s.pend == MAXP && !wb_flag_valid) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_exec(mstate_t s);
        int src = (wb_flag_valid && s.pend == 1) ? int'(wb_status) : s.status;
        return exp_ready(s) && holds(int'(issue_cond), src);
    endfunction

    function automatic mstate_t model_next(mstate_t s);
        mstate_t n = s;
        bit rdy, ex, refused;
        if (rst) begin
            n = '{0, 0, 0, 0, int'(ST_IDLE)};
            return n;
        end
        rdy = exp_ready(s);
        ex  = exp_exec(s);
        refused = issue_valid && !rdy && !flush;
        if (refused && n.stall < 255) n.stall++;
        if (flush) begin
            n.pend = 0;
        end else begin
            if (wb_flag_valid) begin
                if (s.pend == 0) n.err = 1;
                else begin
                    n.status = int'(wb_status);
                    n.pend--;
                end
            end
            if (issue_valid && ex && issue_s) n.pend++;
        end
        n.st = refused ? int'(ST_STALLED) : (n.pend > 0 ? int'(ST_INFLIGHT) : int'(ST_IDLE));
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    always @(negedge clk) begin
        if (checking) begin
            chk("status_q", int'(status_q), m.status);
            chk("pend_cnt", int'(pend_cnt), m.pend);
            chk("stall_cnt", int'(stall_cnt), m.stall);
            chk("err", int'(err), m.err);
            chk("state", int'(dut.state_q), m.st);
            chk("issue_ready", int'(issue_ready), int'(exp_ready(m)));
            if (issue_valid && exp_ready(m))
                chk("issue_exec", int'(issue_exec), int'(exp_exec(m)));
        end
    end

    task automatic drive(bit v, int c, bit s, bit w, int ws, bit f);
        issue_valid   = v;
        issue_cond    = 4'(c);
        issue_s       = s;
        wb_flag_valid = w;
        wb_status     = 4'(ws);
        flush         = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 14, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("rst_ready", int'(issue_ready), 0);
        tick();
        rst = 1'b0;
        drive(0, 14, 0, 0, 0, 0);
        chk("rst_status", int'(status_q), 0);
        chk("rst_pend", int'(pend_cnt), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        chk("rst_err", int'(err), 0);
        checking = 1'b1;

        // Basic condition evaluation against cleared flags
        drive(1, 0, 0, 0, 0, 0); #1;
        chk("eq_ready", int'(issue_ready), 1);
        chk("eq_exec", int'(issue_exec), 0);
        tick();
        drive(1, 1, 0, 0, 0, 0); #1;
        chk("ne_exec", int'(issue_exec), 1);
        tick();
        drive(1, 15, 0, 0, 0, 0); #1;
        chk("nk_ready", int'(issue_ready), 1);
        chk("nk_exec", int'(issue_exec), 0);
        tick();

        // Condition-failed flag setter does not count as pending
        drive(1, 0, 1, 0, 0, 0); #1;
        chk("fail_s_exec", int'(issue_exec), 0);
        tick();
        chk("fail_s_pend", int'(pend_cnt), 0);

        // ADDS then BEQ: stall until writeback, forwarded Z accepts BEQ
        drive(1, 14, 1, 0, 0, 0); #1;
        chk("adds_exec", int'(issue_exec), 1);
        tick();
        chk("adds_pend", int'(pend_cnt), 1);
        drive(1, 0, 0, 0, 0, 0); #1;
        chk("beq_stall", int'(issue_ready), 0);
        tick();
        chk("beq_state", int'(dut.state_q), int'(ST_STALLED));
        chk("beq_stallcnt", int'(stall_cnt), 1);
        #1;
        tick();
        chk("beq_stallcnt2", int'(stall_cnt), 2);
        drive(1, 0, 0, 1, 8, 0); #1;
        chk("beq_fwd_ready", int'(issue_ready), 1);
        chk("beq_fwd_exec", int'(issue_exec), 1);
        tick();
        chk("beq_status", int'(status_q), 8);
        chk("beq_pend", int'(pend_cnt), 0);

        // Fill to MAX_PEND, then overlap a new writer with a retirement
        for (int i = 0; i < 3; i++) begin
            drive(1, 14, 1, 0, 0, 0);
            tick();
        end
        chk("full_pend", int'(pend_cnt), 3);
        drive(1, 14, 1, 0, 0, 0); #1;
        chk("full_ready", int'(issue_ready), 0);
        tick();
        drive(1, 14, 1, 1, 4, 0); #1;
        chk("full_wb_ready", int'(issue_ready), 1);
        tick();
        chk("full_wb_pend", int'(pend_cnt), 3);
        chk("full_wb_status", int'(status_q), 4);

        // Flush discards pending and masks a coincident writeback
        drive(0, 14, 0, 1, 2, 0);
        tick();
        chk("pre_flush_pend", int'(pend_cnt), 2);
        drive(0, 14, 0, 1, 15, 1);
        tick();
        chk("flush_pend", int'(pend_cnt), 0);
        chk("flush_status", int'(status_q), 2);
        chk("flush_state", int'(dut.state_q), int'(ST_IDLE));
        chk("flush_err", int'(err), 0);
        drive(0, 14, 0, 1, 9, 0);
        tick();
        chk("orphan_err", int'(err), 1);
        chk("orphan_status", int'(status_q), 2);
        drive(0, 14, 0, 0, 0, 0);
        tick();
        chk("err_sticky", int'(err), 1);

        // Long blocked request saturates the stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 14, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        repeat (300) tick();
        chk("stall_sat", int'(stall_cnt), 255);
        rst = 1'b1;
        drive(0, 14, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        chk("rst_mid_stall_pend", int'(pend_cnt), 0);
        chk("rst_mid_stall_cnt", int'(stall_cnt), 0);

        // Randomized traffic, checked each cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            bit w;
            w = (m.pend > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), w, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 39) == 0));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 14, 0, 0, 0, 0);
        tick();
        checking = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/flag_scheduler.md
FLAG_SCHEDULER -- requirements
Module: flag_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk is the single clock and rst is the synchronous active-high reset.
REQ-002 Parameter MAX_PEND, default 3: maximum number of in-flight flag-setting instructions, in the range 1..3.
REQ-003 Ports SHALL be as follows, name direction width meaning:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  issue_valid  in  1  ID-stage instruction requests issue
  issue_cond  in  4  ARM condition field; 0000=EQ … 1110=AL, 1111=NK
  issue_s  in  1  requesting instruction updates flags (S bit)
  issue_ready  out  1  issue accepted this cycle when issue_valid is high
  issue_exec  out  1  condition passed; meaningful only when issue_valid and issue_ready are both high
  wb_flag_valid  in  1  a flag-setting instruction retires its flags this cycle
  wb_status  in  4  retiring flags {Z,C,N,V}, with bit3=Z, bit2=C, bit1=N, bit0=V
  flush  in  1  pipeline flush; kills all in-flight instructions
  status_q  out  4  architectural flag register {Z,C,N,V}
  pend_cnt  out  2  in-flight flag writers
  stall_cnt  out  8  saturating count of stalled cycles
  err  out  1  sticky flag: writeback received with nothing pending

Function
REQ-004 Condition evaluation SHALL follow the ARM mapping:
  EQ = Z; NE = !Z; CS = C; CC = !C; MI = N; PL = !N; VS = V; VC = !V
  HI = C & !Z; LS = !C | Z
  GE = (N==V); LT = (N!=V)
  GT = !Z & (N==V); LE = Z | (N!=V)
  AL = 1; NK = 0
REQ-005 Evaluation source SHALL be wb_status when wb_flag_valid is high and pend_cnt==1, and status_q otherwise (same-cycle forwarding).
REQ-006 An issue with cond AL or NK SHALL never stall on flags.
REQ-007 An issue with any other cond SHALL stall (issue_ready=0) while effective pending is nonzero, where effective pending = pend_cnt minus wb_flag_valid.
REQ-008 An issue with issue_s=1 SHALL also stall when pend_cnt==MAX_PEND and wb_flag_valid=0.
REQ-009 pend_cnt SHALL increment on an accepted issue with issue_s=1 and issue_exec=1, and SHALL decrement on wb_flag_valid.
REQ-010 When an increment and a decrement coincide in the same cycle, pend_cnt SHALL remain unchanged.
REQ-011 status_q SHALL load wb_status on every wb_flag_valid that is not masked by flush.
REQ-012 When flush=1: pend_cnt SHALL go to 0, wb_flag_valid SHALL be ignored that cycle, status_q SHALL hold, issue_ready SHALL be 0, and the FSM SHALL go to IDLE.
REQ-013 wb_flag_valid with pend_cnt==0 and no flush SHALL set err=1 and SHALL NOT update status_q or pend_cnt; err clears only on rst.
REQ-014 FSM states SHALL be IDLE (pend_cnt==0), INFLIGHT (pend_cnt>0, no blocked request) and STALLED (a valid request was refused last cycle).
REQ-015 FSM next state SHALL be STALLED if issue_valid & !issue_ready & !flush; otherwise INFLIGHT if the next pend_cnt>0; otherwise IDLE.
REQ-016 stall_cnt SHALL increment each cycle in which issue_valid=1 and issue_ready=0 and flush=0, saturating at 255.
REQ-017 issue_ready and issue_exec SHALL be combinational from the current inputs and state; latency from a flag writeback to acceptance of a dependent issue is 0 cycles.
REQ-018 issue_exec SHALL be forced to 0 whenever issue_ready=0.

Reset
REQ-019 On rst: status_q=4'b0000, pend_cnt=0, stall_cnt=0, err=0, FSM=IDLE; issue_ready SHALL be 0 during the reset cycle.
REQ-020 rst SHALL take priority over flush and all other inputs; reset mid-stall SHALL discard the pending count.

Structure
REQ-021 The condition codes (COND_EQ..COND_NK), the status bit positions (Z=3, C=2, N=1, V=0) and the FSM state encoding SHALL reside in a shared package.
REQ-022 Condition evaluation SHALL be a single instance of the existing Condition_Check sub-module, fed by the forwarding mux of REQ-005.
REQ-023 No other sub-modules SHALL be used.

Verification
REQ-024 Reset, then status_q=0 and issue EQ -> issue_ready=1, issue_exec=0; issue NE -> issue_exec=1; issue NK -> issue_exec=0.
REQ-025 Issue ADDS (cond AL, s=1), then issue BEQ next cycle -> BEQ stalls, STALLED entered, stall_cnt increments; wb_flag_valid with wb_status=4'b1000 in a later cycle -> BEQ accepted that same cycle with issue_exec=1, and status_q=4'b1000 the following cycle.
REQ-026 Three accepted s=1 issues with no writeback -> pend_cnt=3; a fourth s=1 AL issue -> issue_ready=0; the same issue together with wb_flag_valid -> accepted, pend_cnt stays 3.
REQ-027 Condition-failed s=1 issue (cond EQ with Z=0, pend_cnt=0) -> issue_exec=0 and pend_cnt unchanged.
REQ-028 With pend_cnt=2, assert flush together with wb_flag_valid -> pend_cnt=0, status_q unchanged, FSM=IDLE, err=0; a subsequent wb_flag_valid -> err=1.
REQ-029 Hold a blocked request for 300 cycles -> stall_cnt=255.
